// File: rtl/debug_pkg.sv
// debug_pkg: types and constants shared by the JTAG debug controller.
//   - dbg_op_e     : JTAG debug instruction opcodes
//   - dbg_state_e  : controller FSM states
//   - dbg_sticky_t : sticky error flags
//   - Stat*        : bit positions of the STATUS capture word
//   - status_word(): packs sticky flags and live status into the capture word
package debug_pkg;

   parameter int unsigned TimeoutDefault = 255;

   typedef enum logic [7:0] {
      OpNop     = 8'h00,
      OpPause   = 8'h01,
      OpResume  = 8'h02,
      OpSetAddr = 8'h03,
      OpWrite   = 8'h04,
      OpRead    = 8'h05,
      OpStatus  = 8'h06,
      OpClrErr  = 8'h07
   } dbg_op_e;

   typedef enum logic [1:0] {
      StIdle      = 2'd0,
      StPauseWait = 2'd1,
      StMemWait   = 2'd2
   } dbg_state_e;

   localparam int unsigned StatCorePaused = 0;
   localparam int unsigned StatBusy       = 1;
   localparam int unsigned StatOverrun    = 2;
   localparam int unsigned StatBadInstr   = 3;
   localparam int unsigned StatTimeout    = 4;
   localparam int unsigned StatDenied     = 5;

   typedef struct packed {
      logic denied;
      logic timeout;
      logic bad_instr;
      logic overrun;
   } dbg_sticky_t;

   function automatic logic [15:0] status_word(input dbg_sticky_t sticky, input logic busy,
                                               input logic core_paused);
      logic [15:0] w;
      w                 = '0;
      w[StatDenied]     = sticky.denied;
      w[StatTimeout]    = sticky.timeout;
      w[StatBadInstr]   = sticky.bad_instr;
      w[StatOverrun]    = sticky.overrun;
      w[StatBusy]       = busy;
      w[StatCorePaused] = core_paused;
      return w;
   endfunction

endpackage

// File: rtl/debug_timeout_ctr.sv
// debug_timeout_ctr: loadable down-counter used to bound the controller's wait states.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : (re)start the count from load_val; pulsed on wait-state entry
//   load_val  : start value (wait budget minus one)
//   enable    : high while the controller is waiting; counts down one per cycle
//   expired   : high in the last budgeted cycle of a wait (count reached zero)
module debug_timeout_ctr #(
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [Width-1:0] load_val,
   input  logic             enable,
   output logic             expired
);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (enable && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = enable && (cnt_q == '0);

endmodule

// File: rtl/jtag_debug_ctrl.sv
// jtag_debug_ctrl: executes debug commands delivered by a JTAG TAP on Update-DR.
// Commands pause/resume the core, set a word address, perform single memory
// reads/writes (only while the core is halted) and report status.
//   clk, rst                  : clock, asynchronous active-high reset
//   upd_valid/instr/data      : command strobe, opcode and operand from the TAP
//   cap_valid, cap_data       : result word for the next Capture-DR, with strobe
//   core_pause, core_paused   : halt request to the core and its acknowledge
//   mem_req/we/addr/wdata     : memory request, held until mem_ack
//   mem_rdata, mem_ack        : read data and one-cycle completion
//   busy                      : controller is waiting on the core or memory
module jtag_debug_ctrl
   import debug_pkg::*;
#(
   parameter int unsigned TIMEOUT = TimeoutDefault
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        upd_valid,
   input  logic [7:0]  upd_instr,
   input  logic [15:0] upd_data,
   output logic        cap_valid,
   output logic [15:0] cap_data,
   output logic        core_pause,
   input  logic        core_paused,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack,
   output logic        busy
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);
   // Loaded on entry; reaching zero marks the TIMEOUT-th cycle spent waiting.
   localparam logic [CntW-1:0] TmoLoad = CntW'(TIMEOUT - 1);

   dbg_state_e  state_q, state_d;
   logic [15:0] addr_q, addr_d;
   dbg_sticky_t sticky_q, sticky_d;
   logic        core_pause_q, core_pause_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [15:0] mem_wdata_q, mem_wdata_d;
   logic [15:0] cap_data_q, cap_data_d;
   logic        cap_valid_q, cap_valid_d;
   logic        tmo_load, tmo_expired, in_wait;

   assign in_wait = (state_q != StIdle);

   debug_timeout_ctr #(
      .Width (CntW)
   ) u_timeout_ctr (
      .clk      (clk),
      .rst      (rst),
      .load     (tmo_load),
      .load_val (TmoLoad),
      .enable   (in_wait),
      .expired  (tmo_expired)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      sticky_d     = sticky_q;
      core_pause_d = core_pause_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_wdata_d  = mem_wdata_q;
      cap_data_d   = cap_data_q;
      cap_valid_d  = 1'b0;
      tmo_load     = 1'b0;

      case (state_q)
         StIdle: begin
            if (upd_valid) begin
               case (upd_instr)
                  OpNop: ;
                  OpPause: begin
                     core_pause_d = 1'b1;
                     state_d      = StPauseWait;
                     tmo_load     = 1'b1;
                  end
                  OpResume:  core_pause_d = 1'b0;
                  OpSetAddr: addr_d = upd_data;
                  OpWrite, OpRead: begin
                     if (core_paused) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = (upd_instr == OpWrite);
                        mem_wdata_d = upd_data;
                        state_d     = StMemWait;
                        tmo_load    = 1'b1;
                     end else begin
                        sticky_d.denied = 1'b1;
                     end
                  end
                  OpStatus: begin
                     cap_data_d  = status_word(sticky_q, busy, core_paused);
                     cap_valid_d = 1'b1;
                  end
                  OpClrErr: sticky_d = '0;
                  default:  sticky_d.bad_instr = 1'b1;
               endcase
            end
         end

         StPauseWait: begin
            if (upd_valid) sticky_d.overrun = 1'b1;
            if (core_paused) begin
               state_d = StIdle;
            end else if (tmo_expired) begin
               // The pause request stays asserted; only the wait is abandoned.
               sticky_d.timeout = 1'b1;
               state_d          = StIdle;
            end
         end

         StMemWait: begin
            if (upd_valid) sticky_d.overrun = 1'b1;
            if (mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = StIdle;
               addr_d    = addr_q + 16'd1;
               if (!mem_we_q) begin
                  cap_data_d  = mem_rdata;
                  cap_valid_d = 1'b1;
               end
            end else if (tmo_expired) begin
               mem_req_d        = 1'b0;
               sticky_d.timeout = 1'b1;
               state_d          = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         addr_q       <= '0;
         sticky_q     <= '0;
         core_pause_q <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= '0;
         cap_data_q   <= '0;
         cap_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         sticky_q     <= sticky_d;
         core_pause_q <= core_pause_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_wdata_q  <= mem_wdata_d;
         cap_data_q   <= cap_data_d;
         cap_valid_q  <= cap_valid_d;
      end
   end

   assign busy       = in_wait;
   assign cap_valid  = cap_valid_q;
   assign cap_data   = cap_data_q;
   assign core_pause = core_pause_q;
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = mem_wdata_q;

endmodule

// File: doc/jtag_debug_ctrl.md
JTAG_DEBUG_CTRL -- requirements
Module: jtag_debug_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum wait cycles for mem_ack or core_paused before abort.
REQ-002 The block SHALL have these ports, with clock and reset first:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset; asynchronous, active-high.
- upd_valid  in  1  one-cycle pulse from the JTAG port on Update-DR.
- upd_instr  in  8  latched JTAG instruction.
- upd_data  in  16  latched JTAG data register.
- cap_valid  out  1  one-cycle pulse; cap_data is new.
- cap_data  out  16  word for the JTAG port to capture on its next Capture-DR.
- core_pause  out  1  pause request to the processor core.
- core_paused  in  1  the core acknowledges it is halted.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  16  word address.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data; valid when mem_ack is high.
- mem_ack  in  1  one-cycle completion pulse.
- busy  out  1  high whenever the state is not IDLE.

Function
REQ-003 Opcodes SHALL be: 0x00 NOP, 0x01 PAUSE, 0x02 RESUME, 0x03 SET_ADDR, 0x04 WRITE, 0x05 READ, 0x06 STATUS, 0x07 CLR_ERR.
REQ-004 The FSM SHALL have states IDLE, PAUSE_WAIT and MEM_WAIT.
REQ-005 upd_valid SHALL be accepted only in IDLE; if it arrives in any other state (including the mem_ack cycle), the command is dropped and sticky overrun is set.
REQ-006 SET_ADDR SHALL load addr_reg with upd_data; the new value is visible on mem_addr the next cycle; the state stays IDLE.
REQ-007 WRITE while paused SHALL, on the next cycle, raise mem_req=1, mem_we=1, mem_addr=addr_reg and mem_wdata=upd_data, and move to MEM_WAIT.
REQ-008 READ while paused SHALL be identical to WRITE except that mem_we=0.
REQ-009 In MEM_WAIT, mem_req and all mem_* outputs SHALL be held stable until mem_ack.
REQ-010 On the mem_ack cycle the block SHALL: drop mem_req the next cycle, return to IDLE the next cycle, and increment addr_reg with wrap 0xFFFF->0x0000.
REQ-011 For READ, cap_data SHALL equal mem_rdata sampled on the ack cycle, and cap_valid SHALL pulse the next cycle.
REQ-012 WRITE or READ with core_paused=0 SHALL issue no request, set sticky denied, and leave addr_reg unchanged.
REQ-013 PAUSE SHALL set core_pause=1 the next cycle and enter PAUSE_WAIT; when core_paused=1 the FSM returns to IDLE; if core_paused is already 1, PAUSE_WAIT lasts one cycle.
REQ-014 RESUME SHALL clear core_pause the next cycle; the state stays IDLE.
REQ-015 If MEM_WAIT or PAUSE_WAIT lasts TIMEOUT cycles with no response, the block SHALL drop mem_req, set sticky timeout and return to IDLE; core_pause keeps its value.
REQ-016 STATUS SHALL set cap_data = {10'b0, denied, timeout, bad_instr, overrun, busy, core_paused} and pulse cap_valid the next cycle.
REQ-017 CLR_ERR SHALL clear all four sticky bits the next cycle.
REQ-018 NOP and undefined opcodes SHALL cause no action; undefined opcodes also set sticky bad_instr.
REQ-019 A mem_ack received while not in MEM_WAIT SHALL be ignored.

Reset
REQ-020 When rst is asserted, the block SHALL immediately force: state IDLE, addr_reg 0, all sticky bits 0, and every output 0 (cap_data, cap_valid, core_pause, mem_*, busy).
REQ-021 Reset asserted mid-transaction SHALL abandon the transaction with no pending request after release.

Structure
REQ-022 The opcode enum, state enum, status-bit indices and the TIMEOUT default SHALL live in shared package debug_pkg.
REQ-023 The block SHALL have one sub-module, debug_timeout_ctr: a loadable down-counter that is cleared on state entry and flags expiry.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- PAUSE with core_paused raised 3 cycles later -> busy for 4 cycles, then core_pause=1 and state IDLE.
- Paused; SET_ADDR 0xFFFF, then WRITE 0x1234, ack after 2 cycles -> mem_addr=0xFFFF, mem_wdata=0x1234, addr_reg wraps to 0x0000.
- Paused; READ with mem_rdata=0xBEEF -> cap_valid pulses with cap_data=0xBEEF and addr increments by 1.
- READ while unpaused, then STATUS -> no mem_req; cap_data=0x0020.
- WRITE with mem_ack never asserted -> mem_req drops after TIMEOUT cycles; STATUS returns timeout=1; after CLR_ERR, STATUS returns the sticky bits 0.
- upd_valid on the mem_ack cycle, and rst asserted in MEM_WAIT -> overrun set; after reset, all outputs are 0.
